// File: rtl/br_recover.sv
// Branch resolution and misprediction recovery: pops BOB checkpoints as execute
// resolves branches in order, trains the predictor and repairs history on a mispredict.
module br_recover #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bob_valid_i,
  input  logic [63:0] bob_pc_i,
  input  logic        bob_brdir_i,
  input  logic        bob_ch_we_i,
  input  logic        bob_ch_dir_i,
  input  logic [9:0]  bob_lochist_i,
  input  logic [11:0] bob_bhr_i,
  input  logic [3:0]  bob_rasptr_i,
  output logic        bob_re_o,
  input  logic        ex_br_valid_i,
  input  logic        ex_br_taken_i,
  input  logic [63:0] ex_br_target_i,
  output logic        ex_br_ready_o,
  output logic        upd_valid_o,
  output logic [63:0] upd_pc_o,
  output logic        upd_taken_o,
  output logic        upd_ch_we_o,
  output logic        upd_ch_dir_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic [11:0] restore_bhr_o,
  output logic [9:0]  restore_lochist_o,
  output logic [3:0]  restore_rasptr_o,
  output logic        flush_o,
  output logic [15:0] mispred_cnt_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state_r, state_nxt;
  logic [3:0]  fcnt_r, fcnt_nxt;
  logic        accept, mispred;

  logic        upd_valid_r, upd_taken_r, upd_ch_we_r, upd_ch_dir_r;
  logic [63:0] upd_pc_r, redirect_pc_r;
  logic        redirect_valid_r, flush_r;
  logic [11:0] restore_bhr_r;
  logic [9:0]  restore_lochist_r;
  logic [3:0]  restore_rasptr_r;
  logic [15:0] mispred_cnt_r;

  // Handshake with execute/BOB; nothing is accepted while flushing
  always_comb begin
    ex_br_ready_o = 1'b0;
    case (state_r)
      IDLE:    ex_br_ready_o = bob_valid_i;
      FLUSH:   ex_br_ready_o = 1'b0;
      default: ex_br_ready_o = 1'b0;
    endcase
    accept   = ex_br_valid_i & ex_br_ready_o;
    bob_re_o = accept;
    mispred  = accept & (ex_br_taken_i != bob_brdir_i);
  end

  // Next state; the counter is preloaded so FLUSH lasts exactly FLUSH_CYCLES cycles
  always_comb begin
    state_nxt = state_r;
    fcnt_nxt  = fcnt_r;
    case (state_r)
      IDLE: begin
        if (mispred) begin
          state_nxt = FLUSH;
          fcnt_nxt  = 4'(FLUSH_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (fcnt_r == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          fcnt_nxt = fcnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        fcnt_nxt  = 4'd0;
      end
    endcase
  end

  // State, counter and flush register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      fcnt_r  <= 4'd0;
      flush_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      fcnt_r  <= fcnt_nxt;
      flush_r <= (state_nxt == FLUSH);
    end
  end

  // Update/redirect pulses; data fields hold their last value between pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upd_valid_r       <= 1'b0;
      upd_pc_r          <= 64'd0;
      upd_taken_r       <= 1'b0;
      upd_ch_we_r       <= 1'b0;
      upd_ch_dir_r      <= 1'b0;
      redirect_valid_r  <= 1'b0;
      redirect_pc_r     <= 64'd0;
      restore_bhr_r     <= 12'd0;
      restore_lochist_r <= 10'd0;
      restore_rasptr_r  <= 4'd0;
      mispred_cnt_r     <= 16'd0;
    end else begin
      upd_valid_r      <= accept;
      redirect_valid_r <= mispred;
      if (accept) begin
        upd_pc_r     <= bob_pc_i;
        upd_taken_r  <= ex_br_taken_i;
        upd_ch_we_r  <= bob_ch_we_i;
        upd_ch_dir_r <= bob_ch_dir_i;
      end
      if (mispred) begin
        redirect_pc_r     <= ex_br_taken_i ? ex_br_target_i : (bob_pc_i + 64'd4);
        restore_bhr_r     <= {bob_bhr_i[10:0], ex_br_taken_i};
        restore_lochist_r <= {bob_lochist_i[8:0], ex_br_taken_i};
        restore_rasptr_r  <= bob_rasptr_i;
        mispred_cnt_r     <= mispred_cnt_r + 16'd1;
      end
    end
  end

  assign upd_valid_o       = upd_valid_r;
  assign upd_pc_o          = upd_pc_r;
  assign upd_taken_o       = upd_taken_r;
  assign upd_ch_we_o       = upd_ch_we_r;
  assign upd_ch_dir_o      = upd_ch_dir_r;
  assign redirect_valid_o  = redirect_valid_r;
  assign redirect_pc_o     = redirect_pc_r;
  assign restore_bhr_o     = restore_bhr_r;
  assign restore_lochist_o = restore_lochist_r;
  assign restore_rasptr_o  = restore_rasptr_r;
  assign flush_o           = flush_r;
  assign mispred_cnt_o     = mispred_cnt_r;

endmodule

// File: tb/tb_br_recover.sv
// Directed bench for br_recover: default instance plus a FLUSH_CYCLES=4 instance on shared inputs.
module tb_br_recover;

  logic        clock, reset_n;
  logic        bob_valid_i, bob_brdir_i, bob_ch_we_i, bob_ch_dir_i;
  logic [63:0] bob_pc_i, ex_br_target_i;
  logic [9:0]  bob_lochist_i;
  logic [11:0] bob_bhr_i;
  logic [3:0]  bob_rasptr_i;
  logic        ex_br_valid_i, ex_br_taken_i;

  logic        bob_re_o, ex_br_ready_o, upd_valid_o, upd_taken_o, upd_ch_we_o, upd_ch_dir_o;
  logic        redirect_valid_o, flush_o;
  logic [63:0] upd_pc_o, redirect_pc_o;
  logic [11:0] restore_bhr_o;
  logic [9:0]  restore_lochist_o;
  logic [3:0]  restore_rasptr_o;
  logic [15:0] mispred_cnt_o;

  logic        f4_re, f4_ready, f4_upd_valid, f4_upd_taken, f4_ch_we, f4_ch_dir;
  logic        f4_redir_valid, f4_flush;
  logic [63:0] f4_upd_pc, f4_redir_pc;
  logic [11:0] f4_bhr;
  logic [9:0]  f4_lochist;
  logic [3:0]  f4_rasptr;
  logic [15:0] f4_cnt;

  int passed = 0;
  int total  = 0;

  br_recover dut (
    .clock(clock), .reset_n(reset_n),
    .bob_valid_i(bob_valid_i), .bob_pc_i(bob_pc_i), .bob_brdir_i(bob_brdir_i),
    .bob_ch_we_i(bob_ch_we_i), .bob_ch_dir_i(bob_ch_dir_i), .bob_lochist_i(bob_lochist_i),
    .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i), .bob_re_o(bob_re_o),
    .ex_br_valid_i(ex_br_valid_i), .ex_br_taken_i(ex_br_taken_i), .ex_br_target_i(ex_br_target_i),
    .ex_br_ready_o(ex_br_ready_o), .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
    .upd_taken_o(upd_taken_o), .upd_ch_we_o(upd_ch_we_o), .upd_ch_dir_o(upd_ch_dir_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .restore_bhr_o(restore_bhr_o), .restore_lochist_o(restore_lochist_o),
    .restore_rasptr_o(restore_rasptr_o), .flush_o(flush_o), .mispred_cnt_o(mispred_cnt_o)
  );

  br_recover #(.FLUSH_CYCLES(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .bob_valid_i(bob_valid_i), .bob_pc_i(bob_pc_i), .bob_brdir_i(bob_brdir_i),
    .bob_ch_we_i(bob_ch_we_i), .bob_ch_dir_i(bob_ch_dir_i), .bob_lochist_i(bob_lochist_i),
    .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i), .bob_re_o(f4_re),
    .ex_br_valid_i(ex_br_valid_i), .ex_br_taken_i(ex_br_taken_i), .ex_br_target_i(ex_br_target_i),
    .ex_br_ready_o(f4_ready), .upd_valid_o(f4_upd_valid), .upd_pc_o(f4_upd_pc),
    .upd_taken_o(f4_upd_taken), .upd_ch_we_o(f4_ch_we), .upd_ch_dir_o(f4_ch_dir),
    .redirect_valid_o(f4_redir_valid), .redirect_pc_o(f4_redir_pc),
    .restore_bhr_o(f4_bhr), .restore_lochist_o(f4_lochist),
    .restore_rasptr_o(f4_rasptr), .flush_o(f4_flush), .mispred_cnt_o(f4_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and land 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_bob(input logic [63:0] pc, input logic brdir, input logic [11:0] bhr,
                         input logic [9:0] loh, input logic [3:0] ras);
    bob_valid_i = 1'b1; bob_pc_i = pc; bob_brdir_i = brdir;
    bob_bhr_i = bhr; bob_lochist_i = loh; bob_rasptr_i = ras;
  endtask

  task automatic idle_inputs();
    bob_valid_i = 1'b0; ex_br_valid_i = 1'b0; ex_br_taken_i = 1'b0;
    bob_ch_we_i = 1'b0; bob_ch_dir_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bob_pc_i = 64'd0; bob_brdir_i = 1'b0; bob_lochist_i = 10'd0; bob_bhr_i = 12'd0;
    bob_rasptr_i = 4'd0; ex_br_target_i = 64'd0;
    reset_n = 1'b0;
    #12;
    total++; if ({upd_valid_o, redirect_valid_o, flush_o, upd_pc_o, redirect_pc_o} !== 131'd0)
      $display("FAIL reset_outputs: got %h expected 0", {upd_valid_o, redirect_valid_o, flush_o, upd_pc_o, redirect_pc_o}); else passed++;
    total++; if ({restore_bhr_o, restore_lochist_o, restore_rasptr_o, mispred_cnt_o} !== 42'd0)
      $display("FAIL reset_restore: got %h expected 0", {restore_bhr_o, restore_lochist_o, restore_rasptr_o, mispred_cnt_o}); else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_correct();
    set_bob(64'h1000, 1'b1, 12'h123, 10'h045, 4'd2);
    bob_ch_we_i = 1'b1; bob_ch_dir_i = 1'b0;
    ex_br_valid_i = 1'b1; ex_br_taken_i = 1'b1;
    #1;
    total++; if ({bob_re_o, ex_br_ready_o} !== 2'b11)
      $display("FAIL correct_pop: got %b expected 11", {bob_re_o, ex_br_ready_o}); else passed++;
    tick();
    idle_inputs();
    total++; if ({upd_valid_o, upd_taken_o, upd_ch_we_o, upd_ch_dir_o} !== 4'b1110)
      $display("FAIL correct_upd: got %b expected 1110", {upd_valid_o, upd_taken_o, upd_ch_we_o, upd_ch_dir_o}); else passed++;
    total++; if (upd_pc_o !== 64'h1000)
      $display("FAIL correct_upd_pc: got %h expected 1000", upd_pc_o); else passed++;
    total++; if ({redirect_valid_o, flush_o, mispred_cnt_o} !== 18'd0)
      $display("FAIL correct_no_redirect: got %h expected 0", {redirect_valid_o, flush_o, mispred_cnt_o}); else passed++;
    tick();
    total++; if (upd_valid_o !== 1'b0)
      $display("FAIL correct_single_pulse: got %b expected 0", upd_valid_o); else passed++;
  endtask

  task automatic test_mispred_not_taken();
    set_bob(64'h2000, 1'b1, 12'hABC, 10'h155, 4'd3);
    ex_br_valid_i = 1'b1; ex_br_taken_i = 1'b0;
    tick();
    // Keep offering a branch during FLUSH; it must not be taken
    set_bob(64'h2100, 1'b1, 12'h000, 10'h000, 4'd0);
    ex_br_taken_i = 1'b1;
    #1;
    total++; if ({redirect_valid_o, flush_o, upd_valid_o, upd_taken_o} !== 4'b1110)
      $display("FAIL nt_pulses: got %b expected 1110", {redirect_valid_o, flush_o, upd_valid_o, upd_taken_o}); else passed++;
    total++; if (redirect_pc_o !== 64'h2004)
      $display("FAIL nt_redirect_pc: got %h expected 2004", redirect_pc_o); else passed++;
    total++; if ({restore_bhr_o, restore_lochist_o, restore_rasptr_o} !== {12'h578, 10'h2AA, 4'd3})
      $display("FAIL nt_restore: got %h/%h/%h expected 578/2aa/3", restore_bhr_o, restore_lochist_o, restore_rasptr_o); else passed++;
    total++; if (mispred_cnt_o !== 16'd1)
      $display("FAIL nt_count: got %0d expected 1", mispred_cnt_o); else passed++;
    total++; if ({bob_re_o, ex_br_ready_o} !== 2'b00)
      $display("FAIL nt_flush_blocks: got %b expected 00", {bob_re_o, ex_br_ready_o}); else passed++;
    tick();
    total++; if ({flush_o, redirect_valid_o, upd_valid_o, bob_re_o} !== 4'b1000)
      $display("FAIL nt_flush_cycle2: got %b expected 1000", {flush_o, redirect_valid_o, upd_valid_o, bob_re_o}); else passed++;
    total++; if (redirect_pc_o !== 64'h2004)
      $display("FAIL nt_redirect_hold: got %h expected 2004", redirect_pc_o); else passed++;
    ex_br_valid_i = 1'b0;
    tick();
    total++; if ({flush_o, ex_br_ready_o, upd_valid_o} !== 3'b010)
      $display("FAIL nt_flush_end: got %b expected 010", {flush_o, ex_br_ready_o, upd_valid_o}); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_mispred_taken();
    set_bob(64'h3000, 1'b0, 12'h001, 10'h3FF, 4'd5);
    ex_br_valid_i = 1'b1; ex_br_taken_i = 1'b1; ex_br_target_i = 64'h8000;
    tick();
    idle_inputs();
    total++; if (redirect_pc_o !== 64'h8000)
      $display("FAIL tk_redirect_pc: got %h expected 8000", redirect_pc_o); else passed++;
    total++; if ({restore_bhr_o, restore_lochist_o, restore_rasptr_o} !== {12'h003, 10'h3FF, 4'd5})
      $display("FAIL tk_restore: got %h/%h/%h expected 003/3ff/5", restore_bhr_o, restore_lochist_o, restore_rasptr_o); else passed++;
    total++; if ({mispred_cnt_o, redirect_valid_o, upd_taken_o} !== {16'd2, 2'b11})
      $display("FAIL tk_count: got %h expected 0002,11", {mispred_cnt_o, redirect_valid_o, upd_taken_o}); else passed++;
    tick(); tick();
    total++; if (flush_o !== 1'b0)
      $display("FAIL tk_flush_end: got %b expected 0", flush_o); else passed++;
  endtask

  task automatic test_empty_bob();
    ex_br_valid_i = 1'b1; ex_br_taken_i = 1'b0; bob_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({ex_br_ready_o, bob_re_o, upd_valid_o, redirect_valid_o} !== 4'b0000)
        $display("FAIL empty_stall_%0d: got %b expected 0000", i, {ex_br_ready_o, bob_re_o, upd_valid_o, redirect_valid_o}); else passed++;
      tick();
    end
    set_bob(64'h4000, 1'b0, 12'h0, 10'h0, 4'd0);
    #1;
    total++; if ({ex_br_ready_o, bob_re_o} !== 2'b11)
      $display("FAIL empty_accept: got %b expected 11", {ex_br_ready_o, bob_re_o}); else passed++;
    tick();
    idle_inputs();
    total++; if ({upd_valid_o, redirect_valid_o, upd_pc_o} !== {2'b10, 64'h4000})
      $display("FAIL empty_upd: got %b %h expected 10 4000", {upd_valid_o, redirect_valid_o}, upd_pc_o); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    logic [63:0] pc;
    for (int i = 0; i < 4; i++) begin
      pc = 64'h5000 + 64'(i) * 64'd4;
      set_bob(pc, i[0], 12'h0, 10'h0, 4'd0);
      ex_br_valid_i = 1'b1; ex_br_taken_i = i[0];
      #1;
      if (bob_re_o === 1'b1) pops++;
      if (i > 0) begin
        total++; if ({upd_valid_o, upd_pc_o} !== {1'b1, pc - 64'd4})
          $display("FAIL b2b_upd_%0d: got %b %h expected 1 %h", i, upd_valid_o, upd_pc_o, pc - 64'd4); else passed++;
      end
      tick();
    end
    idle_inputs();
    total++; if ({upd_valid_o, upd_pc_o, flush_o} !== {1'b1, 64'h500C, 1'b0})
      $display("FAIL b2b_last: got %b %h %b expected 1 500c 0", upd_valid_o, upd_pc_o, flush_o); else passed++;
    total++; if (pops !== 4)
      $display("FAIL b2b_pops: got %0d expected 4", pops); else passed++;
    set_bob(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 12'h0, 10'h0, 4'd0);
    ex_br_valid_i = 1'b1; ex_br_taken_i = 1'b0;
    tick();
    idle_inputs();
    total++; if ({redirect_valid_o, redirect_pc_o, mispred_cnt_o} !== {1'b1, 64'd0, 16'd3})
      $display("FAIL b2b_wrap_pc: got %b %h %0d expected 1 0 3", redirect_valid_o, redirect_pc_o, mispred_cnt_o); else passed++;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    set_bob(64'h6000, 1'b1, 12'h0, 10'h0, 4'd0);
    ex_br_valid_i = 1'b1; ex_br_taken_i = 1'b0;
    tick();
    idle_inputs();
    total++; if ({flush_o, redirect_valid_o} !== 2'b11)
      $display("FAIL ar_pre_flush: got %b expected 11", {flush_o, redirect_valid_o}); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++; if ({flush_o, redirect_valid_o, upd_valid_o, mispred_cnt_o} !== 19'd0)
      $display("FAIL ar_immediate: got %h expected 0", {flush_o, redirect_valid_o, upd_valid_o, mispred_cnt_o}); else passed++;
    #1 reset_n = 1'b1;
    bob_valid_i = 1'b1;
    #1;
    total++; if (ex_br_ready_o !== 1'b1)
      $display("FAIL ar_idle_ready: got %b expected 1", ex_br_ready_o); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_flush4();
    set_bob(64'h7000, 1'b1, 12'h0, 10'h0, 4'd0);
    ex_br_valid_i = 1'b1; ex_br_taken_i = 1'b0;
    tick();
    idle_inputs();
    total++; if ({f4_redir_valid, f4_redir_pc} !== {1'b1, 64'h7004})
      $display("FAIL f4_redirect: got %b %h expected 1 7004", f4_redir_valid, f4_redir_pc); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if ({f4_flush, flush_o} !== {1'b1, (i < 2) ? 1'b1 : 1'b0})
        $display("FAIL f4_flush_%0d: got %b expected %b", i, {f4_flush, flush_o}, {1'b1, (i < 2) ? 1'b1 : 1'b0}); else passed++;
      tick();
    end
    bob_valid_i = 1'b1;
    #1;
    total++; if ({f4_flush, f4_ready} !== 2'b01)
      $display("FAIL f4_flush_end: got %b expected 01", {f4_flush, f4_ready}); else passed++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispred_not_taken();
    test_mispred_taken();
    test_empty_bob();
    test_back_to_back();
    test_async_reset();
    test_flush4();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
